// File: rtl/eth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : eth_pkg                                                       |
// | Purpose  : Shared definitions for the UDP receive path: one-hot FSM      |
// |            state encoding, UDP header length, IP protocol number and a   |
// |            ones-complement fold helper.                                  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'b0001,
    REC_HEADER = 4'b0010,
    REC_DATA   = 4'b0100,
    REC_END    = 4'b1000
  } udp_rx_state_t;

  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

  // Two end-around-carry folds of a 32-bit ones-complement sum.
  // After the first fold the value is at most 17'h1FFFE, so the second
  // fold can never carry out again.
  function automatic logic [15:0] ones_fold(input logic [31:0] sum);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return s2;
  endfunction

endpackage : eth_pkg
`default_nettype wire

// File: rtl/udp_checksum_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : udp_checksum_acc                                              |
// | Purpose  : 32-bit ones-complement accumulator for the UDP checksum.      |
// |            result is the twice-folded sum INCLUDING the word presented   |
// |            this cycle, so a verdict can be taken on the final word.      |
// | Ports    : clk, rst_n        - clock, synchronous active-low reset       |
// |            clear            - zero the accumulator at the next edge      |
// |            add_en, add_word - add a (up to 17-bit) word this cycle       |
// |            result[15:0]     - folded sum of accumulator + current word   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module udp_checksum_acc
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        add_en,
  input  logic [16:0] add_word,
  output logic [15:0] result
);

  logic [31:0] acc;
  logic [31:0] acc_next;

  assign acc_next = acc + (add_en ? {15'd0, add_word} : 32'd0);
  assign result   = ones_fold(acc_next);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= 32'd0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule : udp_checksum_acc
`default_nettype wire

// File: rtl/udp_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : udp_rx                                                        |
// | Purpose  : UDP receive stage. Parses the 8-byte UDP header from the IP   |
// |            payload stream, validates length and destination port, and   |
// |            forwards payload bytes with a one-cycle registered latency.   |
// | Config   : define UDP_RX_CHECKSUM_EN to add pseudo-header checksum       |
// |            verification; otherwise udp_checksum_error is tied to 0.      |
// | Ports    : clk, rst_n                 - clock, sync active-low reset     |
// |            local_udp_port            - port accepted by this node        |
// |            udp_rx_data, udp_rx_req   - byte stream and frame-start pulse |
// |            upper_layer_data_length   - IP payload length                 |
// |            ip_addr_check_error       - abort from the IP stage           |
// |            ip_rec_source_addr/_destination_addr - pseudo-header addrs    |
// |            udp_rec_rdata/_data_valid - payload byte out                  |
// |            udp_rec_data_length       - payload length (UDP length - 8)   |
// |            udp_rec_source/dest_port  - header ports                      |
// |            udp_rx_end                - pulse after last payload byte     |
// |            udp_port/length/checksum_error - one-cycle error pulses       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module udp_rx
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] local_udp_port,
  input  logic [7:0]  udp_rx_data,
  input  logic        udp_rx_req,
  input  logic [15:0] upper_layer_data_length,
  input  logic        ip_addr_check_error,
  input  logic [31:0] ip_rec_source_addr,
  input  logic [31:0] ip_rec_destination_addr,
  output logic [7:0]  udp_rec_rdata,
  output logic        udp_rec_data_valid,
  output logic [15:0] udp_rec_data_length,
  output logic [15:0] udp_rec_source_port,
  output logic [15:0] udp_rec_dest_port,
  output logic        udp_rx_end,
  output logic        udp_port_error,
  output logic        udp_length_error,
  output logic        udp_checksum_error
);

  udp_rx_state_t state;
  logic [15:0]   cnt;
  logic [15:0]   cnt_inc;
  logic [15:0]   udp_len;
  logic          abort;
  logic          len_bad;
  logic          port_bad;
  logic          data_done;

  assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign abort     = ip_addr_check_error && (state != IDLE);
  assign len_bad   = (udp_len < UDP_HDR_LEN) || (udp_len > upper_layer_data_length);
  assign port_bad  = (udp_rec_dest_port != local_udp_port);
  // Counter value equals the stream offset of the byte on udp_rx_data, so
  // reaching udp_len means every payload byte has been forwarded. The
  // saturation term makes a maximal-length frame terminate cleanly.
  assign data_done = (cnt >= udp_len) || (cnt == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= 16'd0;
      udp_len             <= 16'd0;
      udp_rec_rdata       <= 8'd0;
      udp_rec_data_valid  <= 1'b0;
      udp_rec_data_length <= 16'd0;
      udp_rec_source_port <= 16'd0;
      udp_rec_dest_port   <= 16'd0;
      udp_rx_end          <= 1'b0;
      udp_port_error      <= 1'b0;
      udp_length_error    <= 1'b0;
    end else begin
      udp_rec_data_valid <= 1'b0;
      udp_rx_end         <= 1'b0;
      udp_port_error     <= 1'b0;
      udp_length_error   <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= 16'd0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= 16'd0;
            if (udp_rx_req) begin
              state <= REC_HEADER;
            end
          end
          REC_HEADER: begin
            cnt <= cnt_inc;
            case (cnt)
              16'd0: udp_rec_source_port[15:8] <= udp_rx_data;
              16'd1: udp_rec_source_port[7:0]  <= udp_rx_data;
              16'd2: udp_rec_dest_port[15:8]   <= udp_rx_data;
              16'd3: udp_rec_dest_port[7:0]    <= udp_rx_data;
              16'd4: udp_len[15:8]             <= udp_rx_data;
              16'd5: udp_len[7:0]              <= udp_rx_data;
              16'd7: begin
                if (len_bad) begin
                  udp_length_error <= 1'b1;
                  state            <= REC_END;
                end else if (port_bad) begin
                  udp_port_error <= 1'b1;
                  state          <= REC_END;
                end else begin
                  udp_rec_data_length <= udp_len - UDP_HDR_LEN;
                  state               <= REC_DATA;
                end
              end
              default: ;
            endcase
          end
          REC_DATA: begin
            cnt <= cnt_inc;
            if (data_done) begin
              udp_rx_end <= 1'b1;
              state      <= REC_END;
            end else begin
              udp_rec_rdata      <= udp_rx_data;
              udp_rec_data_valid <= 1'b1;
            end
          end
          REC_END: begin
            cnt   <= cnt_inc;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            cnt   <= 16'd0;
          end
        endcase
      end
    end
  end

`ifdef UDP_RX_CHECKSUM_EN
  logic [15:0] csum_rx;
  logic [7:0]  hi_byte;
  logic        acc_add;
  logic [16:0] acc_word;
  logic [15:0] acc_result;
  logic        csum_err;

  // Header bytes pair up on odd counts; the even-count slots are free and
  // carry the pseudo-header. Address halves are pre-added into a 17-bit
  // word so the whole pseudo-header fits in those four slots. udp_len is
  // complete from count 6 onward, so it is reused as the pseudo length.
  always_comb begin
    acc_add  = 1'b0;
    acc_word = 17'd0;
    if (state == REC_HEADER) begin
      acc_add = 1'b1;
      case (cnt)
        16'd0:   acc_word = {1'b0, ip_rec_source_addr[31:16]}
                          + {1'b0, ip_rec_source_addr[15:0]};
        16'd2:   acc_word = {1'b0, ip_rec_destination_addr[31:16]}
                          + {1'b0, ip_rec_destination_addr[15:0]};
        16'd4:   acc_word = {9'd0, IP_PROTO_UDP};
        16'd6:   acc_word = {1'b0, udp_len};
        default: acc_word = {1'b0, hi_byte, udp_rx_data};
      endcase
    end else if (state == REC_DATA) begin
      if (!data_done) begin
        acc_add  = cnt[0];
        acc_word = {1'b0, hi_byte, udp_rx_data};
      end else begin
        // Odd payload: the last byte is still parked in hi_byte.
        acc_add  = udp_len[0];
        acc_word = {1'b0, hi_byte, 8'h00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_rx  <= 16'd0;
      hi_byte  <= 8'd0;
      csum_err <= 1'b0;
    end else begin
      csum_err <= 1'b0;
      if ((state != IDLE) && !cnt[0]) begin
        hi_byte <= udp_rx_data;
      end
      if ((state == REC_HEADER) && (cnt == 16'd6)) begin
        csum_rx[15:8] <= udp_rx_data;
      end
      if ((state == REC_HEADER) && (cnt == 16'd7)) begin
        csum_rx[7:0] <= udp_rx_data;
      end
      // A zero checksum field means the sender did not compute one.
      if ((state == REC_DATA) && !abort && data_done) begin
        csum_err <= (csum_rx != 16'd0) && (acc_result != 16'hFFFF);
      end
    end
  end

  udp_checksum_acc u_checksum_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .add_en   (acc_add),
    .add_word (acc_word),
    .result   (acc_result)
  );

  assign udp_checksum_error = csum_err;
`else
  logic unused_pseudo_addr;
  assign unused_pseudo_addr = ^{ip_rec_source_addr, ip_rec_destination_addr};
  assign udp_checksum_error = 1'b0;
`endif

endmodule : udp_rx
`default_nettype wire

// File: tb/tb_udp_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_udp_rx                                                     |
// | Purpose  : Self-checking bench for udp_rx. Frames are built as byte      |
// |            arrays; expected payload, pulse counts and pulse timing are   |
// |            derived from the UDP framing rules and compared against a     |
// |            negedge monitor. Honours UDP_RX_CHECKSUM_EN.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_udp_rx;

  localparam logic [15:0] LOCAL_PORT = 16'd5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] local_udp_port;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_req;
  logic [15:0] upper_layer_data_length;
  logic        ip_addr_check_error;
  logic [31:0] ip_rec_source_addr;
  logic [31:0] ip_rec_destination_addr;
  logic [7:0]  udp_rec_rdata;
  logic        udp_rec_data_valid;
  logic [15:0] udp_rec_data_length;
  logic [15:0] udp_rec_source_port;
  logic [15:0] udp_rec_dest_port;
  logic        udp_rx_end;
  logic        udp_port_error;
  logic        udp_length_error;
  logic        udp_checksum_error;

  always #5 clk = ~clk;

  udp_rx dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .local_udp_port          (local_udp_port),
    .udp_rx_data             (udp_rx_data),
    .udp_rx_req              (udp_rx_req),
    .upper_layer_data_length (upper_layer_data_length),
    .ip_addr_check_error     (ip_addr_check_error),
    .ip_rec_source_addr      (ip_rec_source_addr),
    .ip_rec_destination_addr (ip_rec_destination_addr),
    .udp_rec_rdata           (udp_rec_rdata),
    .udp_rec_data_valid      (udp_rec_data_valid),
    .udp_rec_data_length     (udp_rec_data_length),
    .udp_rec_source_port     (udp_rec_source_port),
    .udp_rec_dest_port       (udp_rec_dest_port),
    .udp_rx_end              (udp_rx_end),
    .udp_port_error          (udp_port_error),
    .udp_length_error        (udp_length_error),
    .udp_checksum_error      (udp_checksum_error)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] pay  [0:63];
  logic [7:0] strm [0:127];

  logic [7:0] q_vdat[$];
  int         q_vcyc[$];
  int         q_end[$];
  int         q_perr[$];
  int         q_lerr[$];
  int         q_cerr[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (udp_rec_data_valid) begin
      q_vdat.push_back(udp_rec_rdata);
      q_vcyc.push_back(cyc);
    end
    if (udp_rx_end)         q_end.push_back(cyc);
    if (udp_port_error)     q_perr.push_back(cyc);
    if (udp_length_error)   q_lerr.push_back(cyc);
    if (udp_checksum_error) q_cerr.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fold32(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    while (t[31:16] != 16'd0) t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
    return t[15:0];
  endfunction

  // Ones-complement sum of pseudo-header plus the first n segment bytes.
  function automatic logic [31:0] csum_total(input logic [15:0] ulen, input int n);
    logic [31:0] s;
    logic [7:0]  lo;
    s = {16'd0, ip_rec_source_addr[31:16]} + {16'd0, ip_rec_source_addr[15:0]}
      + {16'd0, ip_rec_destination_addr[31:16]} + {16'd0, ip_rec_destination_addr[15:0]}
      + 32'h0000_0011 + {16'd0, ulen};
    for (int i = 0; i < n; i += 2) begin
      lo = (i + 1 < n) ? strm[i+1] : 8'h00;
      s  = s + {16'd0, strm[i], lo};
    end
    return s;
  endfunction

  // cmode: 0 correct checksum, 1 checksum field zero, 2 payload bit flipped.
  // cut_at: stream index where the frame is cut (-1 none); cut_rst selects
  // reset instead of ip_addr_check_error. stray_at: index of an extra req.
  task automatic send_frame(input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] ulen, input logic [15:0] iplen,
                            input int npad, input int cut_at, input bit cut_rst,
                            input int cmode, input int stray_at);
    int npay, nstrm, r, nvalid, k;
    logic [15:0] cs;
    bit lbad, pbad, accept, cut, hdr_ok, len_exp, port_exp, end_exp, cerr_exp;

    npay = (ulen > 16'd8) ? int'(ulen) - 8 : 0;
    ip_rec_source_addr      = $urandom;
    ip_rec_destination_addr = $urandom;
    upper_layer_data_length = iplen;
    strm[0] = sp[15:8];   strm[1] = sp[7:0];
    strm[2] = dp[15:8];   strm[3] = dp[7:0];
    strm[4] = ulen[15:8]; strm[5] = ulen[7:0];
    strm[6] = 8'h00;      strm[7] = 8'h00;
    for (int j = 0; j < npay; j++) strm[8+j] = pay[j];
    cs = ~fold32(csum_total(ulen, 8 + npay));
    if (cs == 16'h0000) cs = 16'hFFFF;
    if (cmode == 1) cs = 16'h0000;
    strm[6] = cs[15:8];
    strm[7] = cs[7:0];
    if (cmode == 2 && npay > 0) begin
      k = 8 + $urandom_range(0, npay - 1);
      strm[k] = strm[k] ^ (8'h01 << $urandom_range(0, 7));
    end
    nstrm = 8 + npay + npad;
    for (int j = 8 + npay; j < nstrm; j++) strm[j] = $urandom;

    lbad     = (ulen < 16'd8) || (ulen > iplen);
    pbad     = !lbad && (dp != LOCAL_PORT);
    accept   = !lbad && !pbad;
    cut      = (cut_at >= 0);
    hdr_ok   = !cut || (cut_at > 7);
    len_exp  = lbad && hdr_ok;
    port_exp = pbad && hdr_ok;
    end_exp  = accept && (!cut || cut_at > int'(ulen));
    nvalid   = accept ? npay : 0;
    if (accept && cut && (cut_at - 8 < nvalid)) nvalid = (cut_at > 8) ? cut_at - 8 : 0;
`ifdef UDP_RX_CHECKSUM_EN
    cerr_exp = end_exp && (cs != 16'h0000) && (fold32(csum_total(ulen, 8 + npay)) != 16'hFFFF);
`else
    cerr_exp = 1'b0;
`endif

    q_vdat.delete(); q_vcyc.delete(); q_end.delete();
    q_perr.delete(); q_lerr.delete(); q_cerr.delete();

    tick();
    udp_rx_req = 1'b1;
    r = cyc;
    tick();
    udp_rx_req = 1'b0;
    for (int i = 0; i < nstrm; i++) begin
      udp_rx_data         = strm[i];
      ip_addr_check_error = (i == cut_at) && !cut_rst;
      rst_n               = !((i == cut_at) && cut_rst);
      udp_rx_req          = (i == stray_at);
      tick();
    end
    udp_rx_data         = 8'h00;
    ip_addr_check_error = 1'b0;
    rst_n               = 1'b1;
    udp_rx_req          = 1'b0;
    repeat (8) tick();

    check_eq("valid_count", q_vdat.size(), nvalid);
    for (int j = 0; j < nvalid && j < q_vdat.size(); j++)
      check_eq("payload_byte", q_vdat[j], strm[8+j]);
    if (nvalid > 0 && q_vcyc.size() > 0)
      check_eq("first_valid_latency", q_vcyc[0] - r, 10);
    check_eq("end_count", q_end.size(), end_exp);
    if (end_exp && q_end.size() > 0) begin
      check_eq("end_latency", q_end[0] - r, int'(ulen) + 2);
      if (q_vcyc.size() > 0)
        check_eq("end_after_last_valid", q_end[0] - q_vcyc[q_vcyc.size()-1], 1);
    end
    check_eq("len_err_count", q_lerr.size(), len_exp);
    if (len_exp && q_lerr.size() > 0) check_eq("len_err_latency", q_lerr[0] - r, 9);
    check_eq("port_err_count", q_perr.size(), port_exp);
    if (port_exp && q_perr.size() > 0) check_eq("port_err_latency", q_perr[0] - r, 9);
    check_eq("csum_err_count", q_cerr.size(), cerr_exp);
    if (cerr_exp && q_cerr.size() > 0 && q_end.size() > 0)
      check_eq("csum_err_with_end", q_cerr[0], q_end[0]);
    if (cut && cut_rst) begin
      check_eq("rst_src_port", udp_rec_source_port, 16'd0);
      check_eq("rst_data_len", udp_rec_data_length, 16'd0);
    end else begin
      if (!cut || cut_at >= 4) begin
        check_eq("src_port", udp_rec_source_port, sp);
        check_eq("dst_port", udp_rec_dest_port, dp);
      end
      if (accept && hdr_ok) check_eq("data_length", udp_rec_data_length, ulen - 16'd8);
    end
  endtask

  initial begin
    logic [15:0] ulen, iplen, dp;
    int npay, npad, cut_at, nstrm;
    bit cut_rst;

    rst_n                   = 1'b0;
    local_udp_port          = LOCAL_PORT;
    udp_rx_data             = 8'h00;
    udp_rx_req              = 1'b0;
    upper_layer_data_length = 16'd0;
    ip_addr_check_error     = 1'b0;
    ip_rec_source_addr      = 32'd0;
    ip_rec_destination_addr = 32'd0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("reset_valid", udp_rec_data_valid, 1'b0);
    check_eq("reset_rdata", udp_rec_rdata, 8'h00);
    check_eq("reset_len", udp_rec_data_length, 16'd0);
    check_eq("reset_ports", {udp_rec_source_port, udp_rec_dest_port}, 32'd0);
    check_eq("reset_pulses", {udp_rx_end, udp_port_error, udp_length_error, udp_checksum_error}, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal frame: payload DE AD BE EF
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    send_frame(16'd1234, 16'd5000, 16'd12, 16'd12, 0, -1, 1'b0, 0, -1);
    // Wrong destination port
    send_frame(16'd1234, 16'd5001, 16'd12, 16'd12, 0, -1, 1'b0, 0, -1);
    // Length too short, then longer than IP payload
    send_frame(16'd7, 16'd5000, 16'd6, 16'd20, 0, -1, 1'b0, 0, -1);
    for (int j = 0; j < 32; j++) pay[j] = $urandom;
    send_frame(16'd7, 16'd5000, 16'd40, 16'd20, 0, -1, 1'b0, 0, -1);
    // Empty payload with Ethernet padding
    send_frame(16'd99, 16'd5000, 16'd8, 16'd8, 18, -1, 1'b0, 0, -1);
    // Address error at payload byte 2 of 10
    for (int j = 0; j < 10; j++) pay[j] = $urandom;
    send_frame(16'd42, 16'd5000, 16'd18, 16'd18, 0, 10, 1'b0, 0, -1);
    // Odd 5-byte payload: good checksum, flipped bit, zero checksum field
    for (int j = 0; j < 5; j++) pay[j] = $urandom;
    send_frame(16'd53, 16'd5000, 16'd13, 16'd13, 3, -1, 1'b0, 0, -1);
    send_frame(16'd53, 16'd5000, 16'd13, 16'd13, 3, -1, 1'b0, 2, -1);
    send_frame(16'd53, 16'd5000, 16'd13, 16'd13, 3, -1, 1'b0, 1, -1);
    // Reset in the middle of the payload
    for (int j = 0; j < 8; j++) pay[j] = $urandom;
    send_frame(16'd77, 16'd5000, 16'd16, 16'd16, 2, 11, 1'b1, 0, -1);

    for (int t = 0; t < 40; t++) begin
      ulen  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(8, 48));
      iplen = ($urandom_range(0, 5) == 0) ? ulen - 16'd1 : ulen + 16'($urandom_range(0, 10));
      dp    = ($urandom_range(0, 5) == 0) ? LOCAL_PORT + 16'd1 : LOCAL_PORT;
      npay  = (ulen > 16'd8) ? int'(ulen) - 8 : 0;
      npad  = $urandom_range(0, 12);
      nstrm = 8 + npay + npad;
      for (int j = 0; j < npay; j++) pay[j] = $urandom;
      cut_at  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nstrm - 1)) : -1;
      cut_rst = $urandom_range(0, 1);
      send_frame(16'($urandom), dp, ulen, iplen, npad, cut_at, cut_rst,
                 $urandom_range(0, 2),
                 (cut_at < 0 && $urandom_range(0, 2) == 0) ? 3 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_udp_rx
`default_nettype wire
